// File: rtl/hls_macc_motion_pkg.sv
// Shared types and constants for the hls_macc_motion scheduler.
//   sched_state_t  : scheduler FSM state encoding
//   NUM_OPERANDS   : operands per job (core inputs in1..in10)
//   NUM_RESULTS    : results per job (core outputs out1..out3)
//   DEFAULT_DATA_W : default operand/result width
package hls_macc_motion_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } sched_state_t;

  localparam int NUM_OPERANDS   = 10;
  localparam int NUM_RESULTS    = 3;
  localparam int DEFAULT_DATA_W = 32;

endpackage

// File: rtl/hls_macc_motion_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector
//   last        : index of the most recently granted requester
//   enable      : allow a grant this cycle
//   grant       : one-hot grant (all zero when disabled or no request)
//   grant_idx   : encoded index of the granted requester
//   grant_valid : a grant was issued
// The search starts strictly after 'last' and wraps, so the last winner has
// the lowest priority. The pointer register itself lives in the caller.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_valid
);

  always_comb begin
    int idx;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (enable && !grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/hls_macc_motion_sched.sv
// Front-end scheduler sharing one hls_macc_motion core among NUM_REQ
// requesters. Jobs are granted round-robin; operands are held on core_in for
// the whole job, results are returned tagged with the requester ID, and a
// watchdog aborts a job whose core_done never arrives.
//   ap_clk, ap_rst        : clock, async active-high reset
//   req_valid/ready/data  : requester job interface (ready is a one-cycle pulse)
//   rsp_*                 : result interface, held until rsp_ready
//   core_start/done/ready : core ap_start/ap_done/ap_ready (ready unused)
//   core_in, core_out1..3 : core operand bus and result inputs
//   busy                  : FSM not in IDLE
//   jobs_done             : count of completed responses (wraps)
module hls_macc_motion_sched
  import hls_macc_motion_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYC = 16,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*NUM_OPERANDS*DATA_W-1:0] req_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             rsp_err,
  output logic [DATA_W-1:0]                rsp_out1,
  output logic [DATA_W-1:0]                rsp_out2,
  output logic [DATA_W-1:0]                rsp_out3,
  output logic                             core_start,
  input  logic                             core_done,
  input  logic                             core_ready,
  output logic [NUM_OPERANDS*DATA_W-1:0]   core_in,
  input  logic [DATA_W-1:0]                core_out1,
  input  logic [DATA_W-1:0]                core_out2,
  input  logic [DATA_W-1:0]                core_out3,
  output logic                             busy,
  output logic [15:0]                      jobs_done
);

  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int OPS_W = NUM_OPERANDS * DATA_W;
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  sched_state_t          state, state_n;
  logic [ID_W-1:0]       last_q;
  logic [WD_W-1:0]       wd_q;
  logic [15:0]           jobs_done_q;

  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_valid;
  logic                  arb_en;
  logic [OPS_W-1:0]      sel_ops;

  logic                  accept;
  logic                  finish_ok;
  logic                  finish_to;
  logic                  handshake;

  // core_ready does not steer sequencing; it is intentionally left unused.
  logic                  unused_core_ready;
  assign unused_core_ready = core_ready;

  // Gate with ap_rst so no accept pulse is shown while reset is held.
  assign arb_en = (state == IDLE) && !ap_rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req         (req_valid),
    .last        (last_q),
    .enable      (arb_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign req_ready = grant;
  assign busy      = (state != IDLE);
  assign jobs_done = jobs_done_q;

  always_comb begin
    sel_ops = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_idx == ID_W'(r)) begin
        sel_ops = req_data[r*OPS_W +: OPS_W];
      end
    end
  end

  // FSM state register
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and control strobes
  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    finish_ok = 1'b0;
    finish_to = 1'b0;
    handshake = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          accept  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        // A done arriving on the final watchdog cycle still counts as success.
        if (core_done) begin
          finish_ok = 1'b1;
          state_n   = RESP;
        end else if (wd_q == WD_LAST) begin
          finish_to = 1'b1;
          state_n   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          handshake = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Job datapath: operands, start, watchdog
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      core_in    <= '0;
      core_start <= 1'b0;
      wd_q       <= '0;
    end else begin
      if (accept) begin
        core_in    <= sel_ops;
        core_start <= 1'b1;
        wd_q       <= '0;
      end else if (finish_ok || finish_to) begin
        core_start <= 1'b0;
      end else if (state == RUN) begin
        wd_q <= wd_q + 1'b1;
      end
    end
  end

  // Response registers, pointer, completion counter
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_id      <= '0;
      rsp_out1    <= '0;
      rsp_out2    <= '0;
      rsp_out3    <= '0;
      last_q      <= LAST_RST;
      jobs_done_q <= '0;
    end else begin
      if (accept) begin
        rsp_id <= grant_idx;
      end
      if (finish_ok) begin
        rsp_out1  <= core_out1;
        rsp_out2  <= core_out2;
        rsp_out3  <= core_out3;
        rsp_err   <= 1'b0;
        rsp_valid <= 1'b1;
      end else if (finish_to) begin
        rsp_out1  <= '0;
        rsp_out2  <= '0;
        rsp_out3  <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
      end else if (handshake) begin
        rsp_valid   <= 1'b0;
        jobs_done_q <= jobs_done_q + 16'd1;
        // Pointer advances only once the job is fully retired.
        last_q      <= rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_hls_macc_motion_sched.sv
module tb_hls_macc_motion_sched;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;
  localparam int ID_W        = 2;

  logic                         ap_clk = 1'b0;
  logic                         ap_rst;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*10*DATA_W-1:0] req_data;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [ID_W-1:0]              rsp_id;
  logic                         rsp_err;
  logic [DATA_W-1:0]            rsp_out1, rsp_out2, rsp_out3;
  logic                         core_start;
  logic                         core_done;
  logic                         core_ready;
  logic [10*DATA_W-1:0]         core_in;
  logic [DATA_W-1:0]            core_out1, core_out2, core_out3;
  logic                         busy;
  logic [15:0]                  jobs_done;

  int checks   = 0;
  int failures = 0;

  always #5 ap_clk = ~ap_clk;

  hls_macc_motion_sched #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .ID_W        (ID_W)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_out1   (rsp_out1),
    .rsp_out2   (rsp_out2),
    .rsp_out3   (rsp_out3),
    .core_start (core_start),
    .core_done  (core_done),
    .core_ready (core_ready),
    .core_in    (core_in),
    .core_out1  (core_out1),
    .core_out2  (core_out2),
    .core_out3  (core_out3),
    .busy       (busy),
    .jobs_done  (jobs_done)
  );

  // Four-state core model; 'hang' turns it into a stub that never finishes.
  logic [1:0] cst;
  logic       hang;
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) cst <= 2'd0;
    else if (cst == 2'd0) cst <= core_start ? 2'd1 : 2'd0;
    else cst <= cst + 2'd1;
  end
  assign core_done  = (cst == 2'd3) && !hang;
  assign core_ready = core_done;

  wire [31:0] op0 = core_in[0*32 +: 32];
  wire [31:0] op1 = core_in[1*32 +: 32];
  wire [31:0] op2 = core_in[2*32 +: 32];
  wire [31:0] op3 = core_in[3*32 +: 32];
  wire [31:0] op4 = core_in[4*32 +: 32];
  wire [31:0] op5 = core_in[5*32 +: 32];
  wire [31:0] op6 = core_in[6*32 +: 32];
  wire [31:0] op7 = core_in[7*32 +: 32];
  wire [31:0] op8 = core_in[8*32 +: 32];
  wire [31:0] op9 = core_in[9*32 +: 32];
  assign core_out1 = op0 * op1 + op2 * op3 + op4;
  assign core_out2 = op5 * op6 + op7;
  assign core_out3 = op8 + op9;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    failures++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int r, input int base);
    for (int k = 0; k < 10; k++) req_data[(r*10+k)*32 +: 32] = 32'(base + k);
  endtask

  task automatic wait_grant(input string tag, output logic [NUM_REQ-1:0] g);
    int n;
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout_fail(tag);
    g = req_ready;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout_fail(tag);
  endtask

  task automatic wait_rsp(input string tag, output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) timeout_fail(tag);
  endtask

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  initial begin
    logic [NUM_REQ-1:0] g;
    int n, lat, t_prev;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    req_data  = '0;
    rsp_ready = 1'b0;
    hang      = 1'b0;
    step();
    step();

    // Reset state, with requests pending
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_core_start", 32'(core_start), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_jobs_done", 32'(jobs_done), 32'h0);
    chk("rst_core_in_zero", 32'(core_in == '0), 32'h1);
    req_valid = '0;
    ap_rst    = 1'b0;
    step();

    // Single job from requester 2, operands 1..10
    set_ops(2, 1);
    req_valid = 4'b0100;
    wait_grant("single_grant_wait", g);
    chk("single_grant", 32'(g), 32'h4);
    step();
    req_valid = '0;
    chk("single_core_start", 32'(core_start), 32'h1);
    chk("single_in1", op0, 32'd1);
    chk("single_in10", op9, 32'd10);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    chk("single_latency", 32'(lat), 32'd5);
    chk("single_start_low", 32'(core_start), 32'h0);
    chk("single_id", 32'(rsp_id), 32'd2);
    chk("single_err", 32'(rsp_err), 32'd0);
    chk("single_out1", rsp_out1, 32'd19);
    chk("single_out2", rsp_out2, 32'd50);
    chk("single_out3", rsp_out3, 32'd19);
    rsp_ready = 1'b1;
    step();
    chk("single_rsp_cleared", 32'(rsp_valid), 32'h0);
    chk("single_jobs_done", 32'(jobs_done), 32'd1);

    // All four requesters from reset, zero-wait consumer
    ap_rst = 1'b1;
    step();
    for (int r = 0; r < NUM_REQ; r++) set_ops(r, r * 16 + 1);
    req_valid = 4'b1111;
    ap_rst    = 1'b0;
    t_prev    = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant("rr_grant_wait", g);
      chk($sformatf("rr_grant%0d", i), 32'(g), 32'(1 << exp_order[i]));
      if (i > 0) chk($sformatf("rr_interval%0d", i), 32'(cyc - t_prev), 32'd6);
      t_prev = cyc;
      step();
    end
    req_valid = '0;
    wait_idle("rr_idle_wait");
    chk("rr_jobs_done", 32'(jobs_done), 32'd5);

    // Backpressure: requester 1 wins after pointer 0, consumer stalls
    rsp_ready = 1'b0;
    set_ops(1, 17);
    req_valid = 4'b0011;
    wait_grant("bp_grant_wait", g);
    chk("bp_grant", 32'(g), 32'h2);
    step();
    req_valid = 4'b0001;
    wait_rsp("bp_rsp_wait", n);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'd1);
      chk("bp_out1", rsp_out1, 32'd707);
      chk("bp_out2", rsp_out2, 32'd530);
      chk("bp_out3", rsp_out3, 32'd51);
      chk("bp_no_ready", 32'(req_ready), 32'h0);
      chk("bp_start_low", 32'(core_start), 32'h0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    wait_grant("bp_next_wait", g);
    chk("bp_next_grant", 32'(g), 32'h1);
    step();
    req_valid = '0;
    wait_idle("bp_idle_wait");
    chk("bp_jobs_done", 32'(jobs_done), 32'd7);

    // Watchdog against a core that never finishes
    hang      = 1'b1;
    rsp_ready = 1'b0;
    set_ops(3, 100);
    req_valid = 4'b1000;
    wait_grant("wd_grant_wait", g);
    chk("wd_grant", 32'(g), 32'h8);
    step();
    req_valid = '0;
    n = 0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      if (core_start) n++;
      step();
      lat++;
    end
    chk("wd_start_cycles", 32'(n), 32'd16);
    chk("wd_err", 32'(rsp_err), 32'd1);
    chk("wd_id", 32'(rsp_id), 32'd3);
    chk("wd_out1", rsp_out1, 32'd0);
    chk("wd_out2", rsp_out2, 32'd0);
    chk("wd_out3", rsp_out3, 32'd0);
    rsp_ready = 1'b1;
    step();
    chk("wd_jobs_done", 32'(jobs_done), 32'd8);

    // Reset two cycles after accept
    req_valid = 4'b0010;
    wait_grant("mid_grant_wait", g);
    chk("mid_grant", 32'(g), 32'h2);
    step();
    step();
    #2;
    ap_rst = 1'b1;
    #1;
    chk("mid_core_start", 32'(core_start), 32'h0);
    chk("mid_busy", 32'(busy), 32'h0);
    chk("mid_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mid_req_ready", 32'(req_ready), 32'h0);
    chk("mid_core_in_zero", 32'(core_in == '0), 32'h1);
    chk("mid_jobs_done", 32'(jobs_done), 32'h0);
    chk("mid_rsp_id", 32'(rsp_id), 32'h0);
    hang      = 1'b0;
    req_valid = 4'b1111;
    step();
    ap_rst = 1'b0;
    wait_grant("post_rst_wait", g);
    chk("post_rst_grant", 32'(g), 32'h1);
    step();
    req_valid = '0;
    wait_idle("post_rst_idle_wait");
    chk("post_rst_jobs_done", 32'(jobs_done), 32'd1);

    // jobs_done wrap from 65535
    force dut.jobs_done_q = 16'hFFFF;
    step();
    release dut.jobs_done_q;
    #1;
    chk("wrap_preload", 32'(jobs_done), 32'hFFFF);
    req_valid = 4'b0001;
    wait_grant("wrap_grant_wait", g);
    step();
    req_valid = '0;
    wait_idle("wrap_idle_wait");
    chk("wrap_jobs_done", 32'(jobs_done), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
